// File: rtl/msx_audio_mixer.sv
// Time-multiplexed stereo mixer: per-channel gain/pan, one channel per cycle, saturated output.
// Optional MIXER_DC_BLOCK_EN adds a per-side DC-blocking high-pass stage after saturation.
module msx_audio_mixer #(
    parameter int NCH    = 8,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int GAIN_W = 4
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    sample_ce,
    input  logic [NCH*IN_W-1:0]     ch_data,
    input  logic [NCH-1:0]          ch_signed,
    input  logic [NCH*GAIN_W-1:0]   ch_gain,
    input  logic [NCH*2-1:0]        ch_pan,
    output logic [OUT_W-1:0]        out_l,
    output logic [OUT_W-1:0]        out_r,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    clip_l,
    output logic                    clip_r,
    output logic                    overrun
);
    localparam int IDX_W     = $clog2(NCH);
    localparam int PROD_W    = IN_W + GAIN_W + 1;
    localparam int ACC_W     = IN_W + GAIN_W + $clog2(NCH) + 1;
    localparam int GAIN_FRAC = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

`ifdef MIXER_DC_BLOCK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SAT = 2'd2, DCF = 2'd3} state_t;
    localparam int DW      = OUT_W + 2;
    localparam int DC_K    = 8;
    localparam logic signed [DW-1:0] DC_MAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic signed [DW-1:0] DC_MIN = {3'b111, {(OUT_W-1){1'b0}}};
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SAT = 2'd2} state_t;
`endif

    // Clamp the scaled accumulator to IN_W; MSB of the result flags a clamp.
    function automatic logic [IN_W:0] clamp_in(input logic signed [ACC_W-1:0] v);
        logic [IN_W:0] res;
        if (v > SAT_MAX) begin
            res = {1'b1, 1'b0, {(IN_W-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            res = {1'b1, 1'b1, {(IN_W-1){1'b0}}};
        end else begin
            res = {1'b0, v[IN_W-1:0]};
        end
        return res;
    endfunction

    // Left-justify an IN_W sample into the OUT_W output word.
    function automatic logic [OUT_W-1:0] to_out(input logic [IN_W-1:0] v);
        logic signed [OUT_W-1:0] w;
        w = OUT_W'($signed(v));
        return w <<< (OUT_W - IN_W);
    endfunction

    state_t                     state_r;
    logic [NCH*IN_W-1:0]        data_r;
    logic [NCH-1:0]             signed_r;
    logic [NCH*GAIN_W-1:0]      gain_r;
    logic [NCH*2-1:0]           pan_r;
    logic [IDX_W-1:0]           idx_r;
    logic signed [ACC_W-1:0]    acc_left_r;
    logic signed [ACC_W-1:0]    acc_right_r;

    logic [IN_W-1:0]            sel_data_s;
    logic [GAIN_W-1:0]          sel_gain_s;
    logic [1:0]                 sel_pan_s;
    logic [IN_W-1:0]            x_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic [IN_W:0]              sat_l_s;
    logic [IN_W:0]              sat_r_s;

    // Current channel operand: offset-binary flips the MSB, then signed multiply by unsigned gain.
    always_comb begin
        sel_data_s = data_r[idx_r*IN_W +: IN_W];
        sel_gain_s = gain_r[idx_r*GAIN_W +: GAIN_W];
        sel_pan_s  = pan_r[idx_r*2 +: 2];
        x_s        = signed_r[idx_r] ? sel_data_s : {~sel_data_s[IN_W-1], sel_data_s[IN_W-2:0]};
        prod_s     = $signed({{(GAIN_W+1){x_s[IN_W-1]}}, x_s}) * $signed({{IN_W{1'b0}}, 1'b0, sel_gain_s});
        prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        sat_l_s    = clamp_in(acc_left_r >>> GAIN_FRAC);
        sat_r_s    = clamp_in(acc_right_r >>> GAIN_FRAC);
    end

`ifdef MIXER_DC_BLOCK_EN
    function automatic logic [OUT_W:0] clamp_dc(input logic signed [DW-1:0] v);
        logic [OUT_W:0] res;
        if (v > DC_MAX) begin
            res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        end else if (v < DC_MIN) begin
            res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
        return res;
    endfunction

    logic [OUT_W-1:0]        dc_x_l_r, dc_x_r_r;
    logic                    pre_clip_l_r, pre_clip_r_r;
    logic signed [DW-1:0]    x_prev_l_r, x_prev_r_r, y_prev_l_r, y_prev_r_r;
    logic signed [DW-1:0]    xe_l_s, xe_r_s;
    logic [OUT_W:0]          dc_l_s, dc_r_s;

    // High-pass y = x - x_prev + y_prev - y_prev/256, evaluated on the saturated sample.
    always_comb begin
        xe_l_s = {{2{dc_x_l_r[OUT_W-1]}}, dc_x_l_r};
        xe_r_s = {{2{dc_x_r_r[OUT_W-1]}}, dc_x_r_r};
        dc_l_s = clamp_dc(xe_l_s - x_prev_l_r + y_prev_l_r - (y_prev_l_r >>> DC_K));
        dc_r_s = clamp_dc(xe_r_s - x_prev_r_r + y_prev_r_r - (y_prev_r_r >>> DC_K));
    end
`endif

    // Mix sequencer: snapshot, accumulate one channel per cycle, saturate and publish.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r     <= IDLE;
            data_r      <= '0;
            signed_r    <= '0;
            gain_r      <= '0;
            pan_r       <= '0;
            idx_r       <= '0;
            acc_left_r  <= '0;
            acc_right_r <= '0;
            out_l       <= '0;
            out_r       <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            clip_l      <= 1'b0;
            clip_r      <= 1'b0;
            overrun     <= 1'b0;
`ifdef MIXER_DC_BLOCK_EN
            dc_x_l_r     <= '0;
            dc_x_r_r     <= '0;
            pre_clip_l_r <= 1'b0;
            pre_clip_r_r <= 1'b0;
            x_prev_l_r   <= '0;
            x_prev_r_r   <= '0;
            y_prev_l_r   <= '0;
            y_prev_r_r   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            clip_l    <= 1'b0;
            clip_r    <= 1'b0;
            if (sample_ce && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (sample_ce) begin
                        data_r      <= ch_data;
                        signed_r    <= ch_signed;
                        gain_r      <= ch_gain;
                        pan_r       <= ch_pan;
                        acc_left_r  <= '0;
                        acc_right_r <= '0;
                        idx_r       <= '0;
                        busy        <= 1'b1;
                        state_r     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sel_pan_s[0]) begin
                        acc_left_r <= acc_left_r + prod_ext_s;
                    end
                    if (sel_pan_s[1]) begin
                        acc_right_r <= acc_right_r + prod_ext_s;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= SAT;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                SAT: begin
`ifdef MIXER_DC_BLOCK_EN
                    dc_x_l_r     <= to_out(sat_l_s[IN_W-1:0]);
                    dc_x_r_r     <= to_out(sat_r_s[IN_W-1:0]);
                    pre_clip_l_r <= sat_l_s[IN_W];
                    pre_clip_r_r <= sat_r_s[IN_W];
                    state_r      <= DCF;
`else
                    out_l     <= to_out(sat_l_s[IN_W-1:0]);
                    out_r     <= to_out(sat_r_s[IN_W-1:0]);
                    clip_l    <= sat_l_s[IN_W];
                    clip_r    <= sat_r_s[IN_W];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
`endif
                end
`ifdef MIXER_DC_BLOCK_EN
                DCF: begin
                    out_l      <= dc_l_s[OUT_W-1:0];
                    out_r      <= dc_r_s[OUT_W-1:0];
                    clip_l     <= pre_clip_l_r | dc_l_s[OUT_W];
                    clip_r     <= pre_clip_r_r | dc_r_s[OUT_W];
                    x_prev_l_r <= xe_l_s;
                    x_prev_r_r <= xe_r_s;
                    y_prev_l_r <= {{2{dc_l_s[OUT_W-1]}}, dc_l_s[OUT_W-1:0]};
                    y_prev_r_r <= {{2{dc_r_s[OUT_W-1]}}, dc_r_s[OUT_W-1:0]};
                    out_valid  <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
`endif
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msx_audio_mixer.sv
// Directed bench for msx_audio_mixer (default build: NCH=8, IN_W=OUT_W=16, latency 10).
module tb_msx_audio_mixer;
    localparam int NCH = 8;
    localparam int LAT = 10;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              sample_ce;
    logic [NCH*16-1:0] ch_data;
    logic [NCH-1:0]    ch_signed;
    logic [NCH*4-1:0]  ch_gain;
    logic [NCH*2-1:0]  ch_pan;
    logic [15:0]       out_l, out_r;
    logic              out_valid, busy, clip_l, clip_r, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    msx_audio_mixer dut (
        .clk_sys(clk_sys), .reset(reset), .sample_ce(sample_ce),
        .ch_data(ch_data), .ch_signed(ch_signed), .ch_gain(ch_gain), .ch_pan(ch_pan),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy),
        .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic clear_ch();
        ch_data   = '0;
        ch_signed = '0;
        ch_gain   = '0;
        ch_pan    = '0;
    endtask

    task automatic set_ch(input int i, input logic [15:0] d, input logic s,
                          input logic [3:0] g, input logic [1:0] p);
        ch_data[i*16 +: 16] = d;
        ch_signed[i]        = s;
        ch_gain[i*4 +: 4]   = g;
        ch_pan[i*2 +: 2]    = p;
    endtask

    // One pass: sample_ce in cycle T, observe cycles T+1 .. T+LAT+2.
    task automatic do_pass(input string tag, input logic [15:0] el, input logic [15:0] er,
                           input logic ecl, input logic ecr);
        int nv = 0;
        int vk = -1;
        logic [15:0] gl = '0, gr = '0;
        logic gcl = 1'b0, gcr = 1'b0;
        step();
        sample_ce = 1'b1;
        step();
        sample_ce = 1'b0;
        chk({tag, "_busy_T1"}, 32'(busy), 32'd1);
        clear_ch();
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k > 1) step();
            if (out_valid) begin
                nv++;
                vk  = k;
                gl  = out_l;
                gr  = out_r;
                gcl = clip_l;
                gcr = clip_r;
            end
            if (k == LAT - 1) chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
            if (k == LAT)     chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
            if (k == LAT + 1) chk({tag, "_pulse_end"}, {29'd0, out_valid, clip_l, clip_r}, 32'd0);
            if (k == LAT + 2) chk({tag, "_hold_l"}, 32'(out_l), 32'(el));
        end
        chk({tag, "_nvalid"}, 32'(nv), 32'd1);
        chk({tag, "_valid_at"}, 32'(vk), 32'(LAT));
        chk({tag, "_out_l"}, 32'(gl), 32'(el));
        chk({tag, "_out_r"}, 32'(gr), 32'(er));
        chk({tag, "_clip"}, {30'd0, gcl, gcr}, {30'd0, ecl, ecr});
    endtask

    initial begin
        int nv, v1, v2;
        logic [15:0] l2;
        reset     = 1'b1;
        sample_ce = 1'b0;
        clear_ch();
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_out", {out_l, out_r}, 32'd0);
        chk("rst_flags", {27'd0, out_valid, busy, clip_l, clip_r, overrun}, 32'd0);

        clear_ch();
        set_ch(0, 16'h1000, 1'b1, 4'd8, 2'b11);
        set_ch(3, 16'h7FFF, 1'b1, 4'd0, 2'b11);
        set_ch(5, 16'h4000, 1'b1, 4'd8, 2'b00);
        do_pass("unity", 16'h1000, 16'h1000, 1'b0, 1'b0);

        clear_ch();
        set_ch(1, 16'h8000, 1'b0, 4'd8, 2'b11);
        set_ch(2, 16'hC000, 1'b0, 4'd8, 2'b01);
        do_pass("offbin", 16'h4000, 16'h0000, 1'b0, 1'b0);

        clear_ch();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h7000, 1'b1, 4'd8, 2'b11);
        do_pass("possat", 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);

        clear_ch();
        set_ch(0, 16'h8000, 1'b1, 4'd15, 2'b10);
        set_ch(1, 16'hC000, 1'b1, 4'd4, 2'b10);
        do_pass("negsat", 16'h0000, 16'h8000, 1'b0, 1'b1);

        chk("no_overrun_yet", 32'(overrun), 32'd0);

        // Overrun: extra sample_ce at T+4, accepted re-trigger at T+10.
        clear_ch();
        set_ch(0, 16'h1000, 1'b1, 4'd8, 2'b11);
        step();
        sample_ce = 1'b1;
        step();
        sample_ce = 1'b0;
        set_ch(0, 16'h2000, 1'b1, 4'd8, 2'b01);
        nv = 0; v1 = -1; v2 = -1; l2 = '0;
        for (int k = 1; k <= 22; k++) begin
            if (k > 1) step();
            if (out_valid) begin
                nv++;
                if (v1 < 0) v1 = k;
                else begin
                    v2 = k;
                    l2 = out_l;
                end
            end
            if (k == 5)  chk("ovr_set", 32'(overrun), 32'd1);
            if (k == 10) chk("ovr_out_l", 32'(out_l), 32'h1000);
            if (k == 11) chk("ovr_reaccept_busy", 32'(busy), 32'd1);
            sample_ce = (k == 4) || (k == 10);
        end
        sample_ce = 1'b0;
        chk("ovr_first_valid", 32'(v1), 32'd10);
        chk("ovr_second_valid", 32'(v2), 32'd20);
        chk("ovr_nvalid", 32'(nv), 32'd2);
        chk("ovr_second_l", 32'(l2), 32'h2000);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset asserted during cycle T+5 aborts the pass.
        clear_ch();
        set_ch(0, 16'h3000, 1'b1, 4'd8, 2'b11);
        step();
        sample_ce = 1'b1;
        step();
        sample_ce = 1'b0;
        nv = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) step();
            if (out_valid) nv++;
            if (k == 6) begin
                chk("rstmid_out", {out_l, out_r}, 32'd0);
                chk("rstmid_flags", {28'd0, busy, clip_l, clip_r, overrun}, 32'd0);
            end
            reset = (k == 5);
        end
        reset = 1'b0;
        chk("rstmid_nvalid", 32'(nv), 32'd0);

        clear_ch();
        set_ch(0, 16'h8000, 1'b1, 4'd15, 2'b10);
        set_ch(1, 16'hC000, 1'b1, 4'd4, 2'b10);
        set_ch(7, 16'h0800, 1'b1, 4'd8, 2'b01);
        do_pass("after_rst", 16'h0800, 16'h8000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/msx_audio_mixer.md
# msx_audio_mixer

Parametrised, time-multiplexed audio mixer for the MSX core, sitting between the sound sources (OPLL, OPL3, SCC, PSG, PCM) and the DAC/I2S outputs. On each sample strobe it snapshots all channels, converts unsigned sources to signed, applies a per-channel 4-bit gain and stereo routing, and accumulates over NCH cycles. It then saturates the result to the output width and presents stereo samples with a valid pulse, replacing ad-hoc fixed-width sums.

## Interface
- NCH, 8, number of input channels (2..16)
- IN_W, 16, per-channel sample width
- OUT_W, 16, output width; must be >= IN_W
- GAIN_W, 4, gain width; unity gain = 8
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_ce  in  1  one-cycle pulse that starts a mix pass
- ch_data  in  NCH*IN_W  channel i at bits [i*IN_W +: IN_W]
- ch_signed  in  NCH  1 = two's complement, 0 = offset binary
- ch_gain  in  NCH*GAIN_W  per-channel gain, 0 = mute
- ch_pan  in  NCH*2  bit0 routes to left, bit1 routes to right
- out_l, out_r  out  OUT_W  signed stereo samples
- out_valid  out  1  one-cycle pulse when out_l/out_r update
- busy  out  1  high from the cycle after an accepted sample_ce until out_valid
- clip_l, clip_r  out  1  one-cycle pulse, coincident with out_valid, when that side saturated
- overrun  out  1  sticky; cleared only by reset

## Operation
- FSM states: IDLE, ACCUM, SAT.
- **IDLE**
  - On sample_ce, snapshot ch_data, ch_signed, ch_gain and ch_pan.
  - Clear acc_l and acc_r, set idx = 0, go to ACCUM.
- **ACCUM** (one channel per cycle)
  - x = ch_signed[idx] ? data : {~data[MSB], data[MSB-1:0]}.
  - p = x * gain, signed, IN_W+GAIN_W+1 bits.
  - If pan bit0 is set, acc_l += p; if pan bit1 is set, acc_r += p.
  - Accumulator width is IN_W+GAIN_W+clog2(NCH)+1, so it never overflows.
  - When idx == NCH-1, go to SAT; otherwise increment idx.
- **SAT**
  - r = acc >>> 3.
  - Clamp r to [-2^(IN_W-1), 2^(IN_W-1)-1]; set clip if clamped.
  - out = clamped value << (OUT_W-IN_W).
  - Pulse out_valid, go to IDLE.
- Outputs hold their last value between passes.
- sample_ce arriving while not in IDLE is ignored and sets overrun.
- Inputs may change freely after the snapshot cycle.
- Gain 0 or pan 00 yields no contribution; the channel still consumes its cycle.
- Reset mid-pass: return to IDLE. out_l/out_r = 0, out_valid = 0, clip = 0, overrun = 0, busy = 0. The aborted pass produces no output.

## Timing
- sample_ce accepted in cycle T; busy is high from T+1.
- ACCUM occupies cycles T+1 .. T+NCH.
- SAT occurs in cycle T+NCH+1; out_l/out_r/out_valid/clip are registered and visible in T+NCH+2.
- busy falls in T+NCH+2.
- Latency is NCH+2 cycles (10 at NCH=8).
- Maximum accepted sample rate is clk_sys/(NCH+2). At 21.48 MHz with NCH=8 this is far above audio rates.
- A sample_ce in the same cycle busy falls (IDLE re-entered) is accepted.

## Configuration
- MIXER_DC_BLOCK_EN
  - Defined: a per-side DC-blocking high-pass stage follows SAT: y = x - x_prev + y_prev - (y_prev >>> 8), at OUT_W+2 internal width, saturated to OUT_W.
  - Defined: the state registers update only on mix passes and reset to 0; latency becomes NCH+3; clip reflects the pre-filter clamp OR the filter clamp.
  - Not defined: the output is the SAT result directly, with latency NCH+2.

## Test plan
- **Unity pass-through.** Defaults; ch0 signed 0x1000, gain 8, pan 11; others gain 0; sample_ce at T.
  - Required: out_l = out_r = 0x1000, out_valid only at T+10, no clip.
- **Offset-binary conversion and routing.** ch1 unsigned 0x8000 and ch2 unsigned 0xC000, gain 8, ch2 pan 01.
  - Required: out_l = 0x4000, out_r = 0x0000.
- **Positive saturation.** ch0–ch3 signed 0x7000, gain 8, pan 11.
  - Required: out_l = out_r = 0x7FFF, clip_l = clip_r = 1 for one cycle.
- **Negative saturation and gain.** ch0 signed 0x8000 at gain 15, ch1 signed 0xC000 at gain 4, pan 10.
  - Required: out_r = 0x8000, clip_r = 1, out_l = 0x0000.
- **Overrun.** Second sample_ce at T+4.
  - Required: overrun = 1 and stays set; exactly one out_valid, at T+10.
  - Required: a sample_ce at T+10 is accepted.
- **Reset mid-pass.** Assert reset at T+5.
  - Required: busy = 0, outputs = 0, no out_valid.
  - Required: a fresh pass afterwards yields the correct result at T'+10.
